// File: rtl/debug_mem_dumper_if.sv
// Signal bundle between the memory dumper, the data-memory debug read port
// and the UART transmitter; the dumper takes the master side.
interface debug_mem_dumper_if #(
    parameter int NB_DATA   = 32,
    parameter int NB_BYTE   = 8,
    parameter int NUM_DIREC = 7
);
    logic                 i_start;
    logic [NUM_DIREC-1:0] o_debug_read_mem_address;
    logic [NB_DATA-1:0]   i_debug_read_mem;
    logic [NB_BYTE-1:0]   o_tx_data;
    logic                 o_tx_start;
    logic                 i_tx_done;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        input  i_start,
        input  i_debug_read_mem,
        input  i_tx_done,
        output o_debug_read_mem_address,
        output o_tx_data,
        output o_tx_start,
        output o_busy,
        output o_done
    );

    modport slave (
        output i_start,
        output i_debug_read_mem,
        output i_tx_done,
        input  o_debug_read_mem_address,
        input  o_tx_data,
        input  o_tx_start,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/debug_mem_dumper.sv
// Streams the whole data memory out through the UART, one word at a time,
// least-significant byte first, on a single-cycle start request.
module debug_mem_dumper #(
    parameter int NB_DATA   = 32,
    parameter int NB_BYTE   = 8,
    parameter int NUM_SLOTS = 128,
    parameter int NUM_DIREC = $clog2(NUM_SLOTS)
) (
    input logic                i_clock,
    input logic                i_reset,
    debug_mem_dumper_if.master bus
);

    localparam logic [NUM_DIREC-1:0] LAST_ADDR = NUM_DIREC'(NUM_SLOTS - 4);
    localparam logic [NUM_DIREC-1:0] WORD_STEP = NUM_DIREC'(4);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LATCH,
        SEND,
        WAIT_TX,
        FINISH
    } state_t;

    state_t               state;
    logic [NUM_DIREC-1:0] address;
    logic [1:0]           byte_cnt;
    logic [NB_DATA-1:0]   word_reg;
    logic [NB_BYTE-1:0]   tx_data;
    logic                 tx_start;
    logic                 busy;
    logic                 done;

    function automatic logic [NB_BYTE-1:0] byte_of(
        input logic [NB_DATA-1:0] word,
        input logic [1:0]         idx
    );
        return word[int'(idx) * NB_BYTE +: NB_BYTE];
    endfunction

    // Outputs are registered: the byte and strobe for SEND are loaded on the
    // edge that enters SEND, so o_tx_start is high exactly while in SEND.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= IDLE;
            address  <= '0;
            byte_cnt <= '0;
            word_reg <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        address  <= '0;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ADDR;
                    end
                end
                // Address is held a full cycle so the falling-edge read settles.
                ADDR: begin
                    state <= LATCH;
                end
                LATCH: begin
                    word_reg <= bus.i_debug_read_mem;
                    byte_cnt <= '0;
                    tx_data  <= byte_of(bus.i_debug_read_mem, 2'd0);
                    tx_start <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        if (byte_cnt < 2'd3) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            tx_data  <= byte_of(word_reg, byte_cnt + 2'd1);
                            tx_start <= 1'b1;
                            state    <= SEND;
                        end else if (address < LAST_ADDR) begin
                            address <= address + WORD_STEP;
                            state   <= ADDR;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_debug_read_mem_address = address;
    assign bus.o_tx_data                = tx_data;
    assign bus.o_tx_start               = tx_start;
    assign bus.o_busy                   = busy;
    assign bus.o_done                   = done;

endmodule

// File: tb/tb_debug_mem_dumper.sv
// Directed bench for debug_mem_dumper: falling-edge memory model, UART
// responder answering each start strobe three cycles later.
module tb_debug_mem_dumper;

    localparam int NB_DATA   = 32;
    localparam int NB_BYTE   = 8;
    localparam int NUM_SLOTS = 128;
    localparam int NUM_DIREC = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    debug_mem_dumper_if #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NUM_DIREC(NUM_DIREC)) bus ();

    debug_mem_dumper #(
        .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NUM_SLOTS(NUM_SLOTS), .NUM_DIREC(NUM_DIREC)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [NUM_SLOTS];
    logic [7:0] tx_q [$];
    int n_checks = 0, n_errors = 0;
    int countdown = 0, stall_idx = -1, stall_len = 0;
    int stall_seen = 0, stall_bad = 0, extra_start = 0;
    int done_cnt = 0, done_gap = -1, cyc = 0, last_txdone_cyc = 0;
    bit mon_clear = 1'b0;

    // Memory debug port registered on the falling edge
    always @(negedge clk) begin
        int b;
        b = int'(bus.o_debug_read_mem_address);
        bus.i_debug_read_mem = {mem[(b + 3) % NUM_SLOTS], mem[(b + 2) % NUM_SLOTS],
                                mem[(b + 1) % NUM_SLOTS], mem[b % NUM_SLOTS]};
    end

    // UART responder and monitor
    always @(negedge clk) begin
        cyc++;
        bus.i_tx_done = 1'b0;
        if (mon_clear) begin
            countdown = 0;
        end else if (bus.o_tx_start) begin
            if (countdown != 0) extra_start++;
            tx_q.push_back(bus.o_tx_data);
            countdown = (tx_q.size() - 1 == stall_idx) ? 3 + stall_len : 3;
        end else if (countdown > 0) begin
            if (tx_q.size() - 1 == stall_idx) begin
                stall_seen++;
                if (bus.o_tx_data !== 8'h05 || bus.o_debug_read_mem_address !== 7'd4) stall_bad++;
            end
            countdown--;
            if (countdown == 0) begin
                bus.i_tx_done   = 1'b1;
                last_txdone_cyc = cyc;
            end
        end
        if (bus.o_done === 1'b1) begin
            done_cnt++;
            done_gap = cyc - last_txdone_cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        mon_clear   = 1'b1;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        mon_clear = 1'b0;
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},     32'(bus.o_debug_read_mem_address), 32'd0);
        check({tag, "_tx_data"},  32'(bus.o_tx_data), 32'd0);
        check({tag, "_tx_start"}, 32'(bus.o_tx_start), 32'd0);
        check({tag, "_busy"},     32'(bus.o_busy), 32'd0);
        check({tag, "_done"},     32'(bus.o_done), 32'd0);
    endtask

    typedef struct {
        string      name;
        logic [7:0] mem_b [4];
        logic [7:0] exp_b [4];
    } vec_t;

    vec_t vecs [5];

    initial begin
        bit ok;
        vecs[0] = '{"inc",   '{8'h11, 8'h22, 8'h33, 8'h44}, '{8'h11, 8'h22, 8'h33, 8'h44}};
        vecs[1] = '{"beef",  '{8'hEF, 8'hBE, 8'hAD, 8'hDE}, '{8'hEF, 8'hBE, 8'hAD, 8'hDE}};
        vecs[2] = '{"zeros", '{8'h00, 8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{"ones",  '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vecs[4] = '{"mixed", '{8'h80, 8'h01, 8'h7F, 8'hFE}, '{8'h80, 8'h01, 8'h7F, 8'hFE}};

        bus.i_start = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) mem[k] = 8'h00;

        mon_clear = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst       = 1'b0;
        mon_clear = 1'b0;

        // Stray tx_done in IDLE must be ignored
        @(negedge clk);
        countdown = 1;
        repeat (4) @(negedge clk);
        check("idle_txdone_busy",  32'(bus.o_busy), 32'd0);
        check("idle_txdone_start", 32'(bus.o_tx_start), 32'd0);

        // Table: first word bytes, LSB first
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 4; k++) mem[k] = vecs[v].mem_b[k];
            do_reset();
            tx_q.delete();
            pulse_start();
            wait_bytes(4, 100, ok);
            check({vecs[v].name, "_got4"}, 32'(ok), 32'd1);
            for (int k = 0; k < 4; k++)
                if (k < tx_q.size())
                    check($sformatf("%s_byte%0d", vecs[v].name, k), 32'(tx_q[k]), 32'(vecs[v].exp_b[k]));
        end

        // Full ramp dump, stall at byte 5, stray start at byte 40
        for (int k = 0; k < NUM_SLOTS; k++) mem[k] = 8'(k);
        do_reset();
        tx_q.delete();
        stall_idx = 5; stall_len = 50; stall_seen = 0; stall_bad = 0;
        extra_start = 0; done_cnt = 0;
        pulse_start();
        wait_bytes(41, 2000, ok);
        check("reach_byte40", 32'(ok), 32'd1);
        pulse_start();
        wait_done(4000, ok);
        check("full_done_seen", 32'(ok), 32'd1);
        check("full_busy_at_done", 32'(bus.o_busy), 32'd1);
        @(negedge clk);
        check("full_done_pulse", 32'(bus.o_done), 32'd0);
        check("full_busy_fall", 32'(bus.o_busy), 32'd0);
        check("full_count", 32'(tx_q.size()), 32'(NUM_SLOTS));
        for (int k = 0; k < tx_q.size() && k < NUM_SLOTS; k++)
            check($sformatf("full_byte%0d", k), 32'(tx_q[k]), 32'(k));
        check("full_done_cnt", 32'(done_cnt), 32'd1);
        check("full_done_gap", 32'(done_gap), 32'd1);
        check("no_extra_start", 32'(extra_start), 32'd0);
        check("stall_hold", 32'(stall_bad), 32'd0);
        check("stall_long", 32'(stall_seen >= 50), 32'd1);
        stall_idx = -1;

        // Reset in WAIT_TX at byte 70, then restart
        do_reset();
        tx_q.delete();
        done_cnt = 0;
        pulse_start();
        wait_bytes(71, 2000, ok);
        check("reach_byte70", 32'(ok), 32'd1);
        @(negedge clk);
        rst       = 1'b1;
        mon_clear = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst       = 1'b0;
        mon_clear = 1'b0;
        repeat (20) @(negedge clk);
        check("midreset_no_done", 32'(done_cnt), 32'd0);
        check("midreset_idle", 32'(bus.o_busy), 32'd0);
        tx_q.delete();
        pulse_start();
        wait_bytes(1, 100, ok);
        check("restart_first", 32'(ok), 32'd1);
        if (tx_q.size() > 0) check("restart_byte0", 32'(tx_q[0]), 32'h00);
        wait_done(4000, ok);
        check("restart_done_seen", 32'(ok), 32'd1);
        bus.i_start = 1'b1;  // arrives during FINISH, must be ignored
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("finish_start_busy", 32'(bus.o_busy), 32'd0);
        check("finish_start_txs", 32'(bus.o_tx_start), 32'd0);
        check("restart_count", 32'(tx_q.size()), 32'(NUM_SLOTS));

        // Start and reset together
        do_reset();
        rst = 1'b1;
        bus.i_start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_start = 1'b0;
        check("startrst_busy", 32'(bus.o_busy), 32'd0);
        repeat (3) @(negedge clk);
        check("startrst_busy_later", 32'(bus.o_busy), 32'd0);
        check("startrst_addr", 32'(bus.o_debug_read_mem_address), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule
